// File: rtl/tt_sweep_checker.sv
// Self-checking truth-table sweeper: drives vec = 0..2^N-1 into an N-input DUT, samples y_in
// and compares it against EXPECTED. Optional macro TT_STOP_ON_ERR_EN ends the sweep at the first mismatch.
module tt_sweep_checker #(
  parameter int                N        = 3,
  parameter logic [(1<<N)-1:0] EXPECTED = 8'h31,
  parameter int                SETTLE   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic [N-1:0] vec,
  input  logic         y_in,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] fail_vec,
  output logic         fail_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [3:0]   SETTLE_CNT = 4'(SETTLE);
  localparam logic [N-1:0] LAST_VEC   = {N{1'b1}};
  localparam logic [N:0]   ERR_MAX    = {1'b1, {N{1'b0}}};
  // With no settle cycles a freshly driven vector is sampled on the very next edge.
  localparam state_e       LOAD_STATE = (SETTLE_CNT != 4'd0) ? S_SETTLE : S_CHECK;

  state_e       state_q;
  logic [3:0]   cnt_q;
  logic [N-1:0] vec_q;
  logic [N:0]   err_q;
  logic [N-1:0] fail_vec_q;
  logic         fail_valid_q;
  logic         busy_q;
  logic         done_q;
  logic         pass_q;

  logic         mismatch;
  logic         sweep_end;
  logic [N:0]   err_d;

  assign mismatch = (y_in != EXPECTED[vec_q]);

`ifdef TT_STOP_ON_ERR_EN
  assign sweep_end = mismatch || (vec_q == LAST_VEC);
`else
  assign sweep_end = (vec_q == LAST_VEC);
`endif

  // err_d feeds both the counter and pass, so an error found on the last vector still fails the sweep.
  always_comb begin
    err_d = err_q;
    if (mismatch && (err_q != ERR_MAX)) err_d = err_q + 1'b1;
  end

  // NOTE: every state register uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      vec_q        <= '0;
      err_q        <= '0;
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            vec_q        <= '0;
            cnt_q        <= SETTLE_CNT;
            err_q        <= '0;
            fail_vec_q   <= '0;
            fail_valid_q <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            state_q      <= LOAD_STATE;
          end
        end
        S_SETTLE: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= S_CHECK;
        end
        S_CHECK: begin
          err_q <= err_d;
          if (mismatch && !fail_valid_q) begin
            fail_vec_q   <= vec_q;
            fail_valid_q <= 1'b1;
          end
          if (sweep_end) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
            state_q <= S_DONE;
          end else begin
            vec_q   <= vec_q + 1'b1;
            cnt_q   <= SETTLE_CNT;
            state_q <= LOAD_STATE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vec        = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_vec   = fail_vec_q;
  assign fail_valid = fail_valid_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: two 3-input instances (SETTLE=1 and SETTLE=0) checked cycle by cycle
// against a reference derived from a per-sweep fault mask applied to the expected truth table.
module tb_tt_sweep_checker;

  localparam logic [7:0] EXP0 = 8'h31;
  localparam logic [7:0] EXP1 = 8'hC6;

  logic       clk = 1'b0;
  logic       reset;
  logic       start      [2];
  logic [2:0] vec        [2];
  logic       y_in       [2];
  logic       busy       [2];
  logic       done       [2];
  logic       pass       [2];
  logic [3:0] err_count  [2];
  logic [2:0] fail_vec   [2];
  logic       fail_valid [2];
  logic [7:0] fault      [2];
  logic [7:0] tt0, tt1;

  int n_total  = 0;
  int n_passed = 0;

  always #5 clk = ~clk;

  assign tt0 = EXP0;
  assign tt1 = EXP1;
  // Behavioural block under test: the golden function with selected vectors inverted.
  assign y_in[0] = tt0[vec[0]] ^ fault[0][vec[0]];
  assign y_in[1] = tt1[vec[1]] ^ fault[1][vec[1]];

  tt_sweep_checker #(.N(3), .EXPECTED(EXP0), .SETTLE(1)) u_dut_s1 (
    .clk(clk), .reset(reset), .start(start[0]), .vec(vec[0]), .y_in(y_in[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err_count[0]),
    .fail_vec(fail_vec[0]), .fail_valid(fail_valid[0])
  );

  tt_sweep_checker #(.N(3), .EXPECTED(EXP1), .SETTLE(0)) u_dut_s0 (
    .clk(clk), .reset(reset), .start(start[1]), .vec(vec[1]), .y_in(y_in[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err_count[1]),
    .fail_vec(fail_vec[1]), .fail_valid(fail_valid[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_passed++;
  endtask

  task automatic check_cleared(input int d, input string tag);
    check($sformatf("%s d%0d vec", tag, d), 32'(vec[d]), 0);
    check($sformatf("%s d%0d busy", tag, d), 32'(busy[d]), 0);
    check($sformatf("%s d%0d done", tag, d), 32'(done[d]), 0);
    check($sformatf("%s d%0d pass", tag, d), 32'(pass[d]), 0);
    check($sformatf("%s d%0d err_count", tag, d), 32'(err_count[d]), 0);
    check($sformatf("%s d%0d fail_vec", tag, d), 32'(fail_vec[d]), 0);
    check($sformatf("%s d%0d fail_valid", tag, d), 32'(fail_valid[d]), 0);
  endtask

  // Runs one sweep on instance d from an idle/done state; entered and left at posedge+1.
  task automatic sweep(input int d, input logic [7:0] m, input bit mid_start);
    int per, nvec, total, errs, first;
    per   = (d == 0) ? 2 : 1;
    errs  = 0;
    first = -1;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        errs++;
        if (first < 0) first = i;
      end
    end
    nvec = 8;
`ifdef TT_STOP_ON_ERR_EN
    if (errs > 0) begin
      nvec = first + 1;
      errs = 1;
    end
`endif
    total    = nvec * per;
    fault[d] = m;
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    for (int k = 0; k < total; k++) begin
      if (k == 0) begin
        check($sformatf("d%0d m=%02h restart err_count", d, m), 32'(err_count[d]), 0);
        check($sformatf("d%0d m=%02h restart fail_valid", d, m), 32'(fail_valid[d]), 0);
      end
      check($sformatf("d%0d m=%02h vec k=%0d", d, m, k), 32'(vec[d]), k / per);
      check($sformatf("d%0d m=%02h busy k=%0d", d, m, k), 32'(busy[d]), 1);
      check($sformatf("d%0d m=%02h done k=%0d", d, m, k), 32'(done[d]), 0);
      start[d] = (mid_start && k == 3) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    start[d] = 1'b0;
    check($sformatf("d%0d m=%02h done", d, m), 32'(done[d]), 1);
    check($sformatf("d%0d m=%02h busy end", d, m), 32'(busy[d]), 0);
    check($sformatf("d%0d m=%02h pass", d, m), 32'(pass[d]), (errs == 0) ? 1 : 0);
    check($sformatf("d%0d m=%02h err_count", d, m), 32'(err_count[d]), errs);
    check($sformatf("d%0d m=%02h fail_valid", d, m), 32'(fail_valid[d]), (first >= 0) ? 1 : 0);
    check($sformatf("d%0d m=%02h fail_vec", d, m), 32'(fail_vec[d]), (first >= 0) ? first : 0);
    check($sformatf("d%0d m=%02h final vec", d, m), 32'(vec[d]), nvec - 1);
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("d%0d m=%02h done held", d, m), 32'(done[d]), 1);
  endtask

  initial begin
    int         d, sel;
    logic [7:0] m;
    reset    = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    fault[0] = '0;
    fault[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_cleared(0, "reset");
    check_cleared(1, "reset");

    sweep(0, 8'h00, 1'b0);   // correct sillyfunction
    sweep(0, EXP0, 1'b0);    // y_in stuck at 0
    sweep(1, 8'hFF, 1'b0);   // y_in inverted, every vector fails
    sweep(0, 8'h20, 1'b1);   // single fault at vec 5, with an ignored mid-sweep start
    sweep(0, 8'h20, 1'b0);   // rerun from DONE gives identical results

    // Reset five cycles into a sweep.
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_cleared(0, "midreset");
    check_cleared(1, "midreset");

    // Start and reset together: reset wins and the block stays idle.
    reset    = 1'b1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    start[0] = 1'b0;
    check_cleared(0, "start+reset");
    @(posedge clk); #1;
    check("start+reset still idle busy", 32'(busy[0]), 0);
    check("start+reset still idle vec", 32'(vec[0]), 0);

    sweep(0, 8'h00, 1'b0);
    sweep(1, 8'h00, 1'b0);

    for (int it = 0; it < 16; it++) begin
      d   = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       m = 8'h00;
        1:       m = 8'h01 << $urandom_range(0, 7);
        default: m = 8'($urandom);
      endcase
      sweep(d, m, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
